// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and de-glitches the PS/2 lines, deframes
// 11-bit frames and hands good bytes to a valid/ready consumer with error pulses.
module ps2_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 32000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]     FiltMax = 8'(FILTER_LEN);
  localparam logic [ToW-1:0] ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Line index 0 is the PS/2 clock, index 1 is the PS/2 data.
  logic [1:0]      meta_q, sync_q, filt_q, filt_d;
  logic [1:0][7:0] fcnt_q, fcnt_d;
  logic            clk_prev_q;
  logic            fall, bit_in;

  state_e          state_q, state_d;
  logic [7:0]      sh_q, sh_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            par_q, par_d;
  logic [ToW-1:0]  to_q, to_d;
  logic            deliver;

  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  // Level filter: a line must disagree with its filtered level for FILTER_LEN samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != filt_q[i]) begin
        if (fcnt_q[i] + 8'd1 == FiltMax) begin
          filt_d[i] = ~filt_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign fall   = clk_prev_q & ~filt_q[0];
  assign bit_in = filt_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q     <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      meta_q     <= {ps2_data_i, ps2_clk_i};
      sync_q     <= meta_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      clk_prev_q <= filt_q[0];
    end
  end

  // Frame FSM; a falling edge always wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    deliver = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (state_q == StIdle || fall) begin
      to_d = '0;
    end else begin
      to_d = to_q + ToW'(1);
    end

    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!bit_in) begin
            state_d = StData;
            cnt_d   = 3'd0;
            par_d   = 1'b0;
          end
        end
        StData: begin
          sh_d  = {bit_in, sh_q[7:1]};
          par_d = par_q ^ bit_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = par_q ^ bit_in;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!bit_in) begin
            ferr_d = 1'b1;
          end else if (!par_q) begin
            perr_d = 1'b1;
          end else begin
            deliver = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && to_q == ToLast) begin
      state_d = StIdle;
      ferr_d  = 1'b1;
    end
  end

  // Output register: a byte arriving while the old one is still held is dropped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (valid_q && !ready_i) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      to_q    <= to_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != StIdle);

endmodule
